// File: rtl/doc_pkg.sv
// Shared document framing constants, geometry and loader state encoding.
// Used by doc_loader and doc_cursor (and the document sender).
package doc_pkg;

  localparam logic [7:0] SIGACK     = 8'hCC;
  localparam logic [7:0] SIGEOF     = 8'hDD;
  localparam logic [7:0] ASCII_BIAS = 8'h20;

  localparam int DOC_ROWS = 15;
  localparam int DOC_COLS = 20;
  localparam int ROW_W    = 4;
  localparam int COL_W    = 5;
  localparam int ADDR_W   = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WACK,
    S_RECV,
    S_WEOF,
    S_FILL,
    S_DONE,
    S_ERR
  } ld_state_e;

  // Printable ASCII maps to its internal code; everything else is a space.
  function automatic logic [7:0] to_code(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) return b - ASCII_BIAS;
    return 8'h00;
  endfunction

endpackage

// File: rtl/doc_cursor.sv
// Row-major row/col cursor over the 15x20 document.
// Clear has priority over advance; last flags cell (14,19).
import doc_pkg::*;

module doc_cursor (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);

  logic [ROW_W-1:0] row_d, row_q;
  logic [COL_W-1:0] col_d, col_q;

  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(DOC_ROWS - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(DOC_COLS - 1);

  // Next cursor position: wrap col at end of row, wrap row at end of page.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (advance) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Cursor registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign last = (row_q == ROW_MAX) && (col_q == COL_MAX);

endmodule

// File: rtl/doc_loader.sv
// Receives SIGACK, 300 ASCII chars, SIGEOF and writes internal codes to memory.
// Optional idle-gap timeout: define DOC_LOADER_TIMEOUT_EN.
import doc_pkg::*;

module doc_loader #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_data_valid,
  input  logic [7:0]        rx_data,
  output logic              write_en,
  output logic [ADDR_W-1:0] write_addr,
  output logic [7:0]        write_data,
  output logic              busy,
  output logic              done,
  output logic              error
);

  ld_state_e state_d, state_q;

  logic             cur_clear;
  logic             cur_adv;
  logic [ROW_W-1:0] cur_row;
  logic [COL_W-1:0] cur_col;
  logic             cur_last;
  logic             timeout_hit;

  logic              write_en_d, write_en_q;
  logic [ADDR_W-1:0] write_addr_d, write_addr_q;
  logic [7:0]        write_data_d, write_data_q;
  logic              busy_d, busy_q;
  logic              done_d, done_q;
  logic              error_d, error_q;

  doc_cursor u_cursor (
    .clk     (clk),
    .reset   (reset),
    .clear   (cur_clear),
    .advance (cur_adv),
    .row     (cur_row),
    .col     (cur_col),
    .last    (cur_last)
  );

`ifdef DOC_LOADER_TIMEOUT_EN
  logic [23:0] gap_d, gap_q;
  logic        gap_active;

  assign gap_active = (state_q == S_WACK) ||
                      (state_q == S_RECV) ||
                      (state_q == S_WEOF);

  assign timeout_hit = gap_active && !rx_data_valid &&
                       (gap_q == TIMEOUT_CYCLES - 24'd1);

  // Gap counter restarts on every byte and on every state change.
  always_comb begin
    gap_d = gap_q + 24'd1;
    if (!gap_active || rx_data_valid || state_d != state_q)
      gap_d = '0;
  end

  // Gap counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) gap_q <= '0;
    else       gap_q <= gap_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic plus cursor control.
  always_comb begin
    state_d   = state_q;
    cur_clear = 1'b0;
    cur_adv   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_WACK;
          cur_clear = 1'b1;
        end
      end
      S_WACK: begin
        if (rx_data_valid && rx_data == SIGACK)
          state_d = S_RECV;
      end
      S_RECV: begin
        if (rx_data_valid) begin
          if (rx_data == SIGEOF) begin
            state_d = S_FILL;
          end else begin
            cur_adv = 1'b1;
            if (cur_last) state_d = S_WEOF;
          end
        end
      end
      S_WEOF: begin
        if (rx_data_valid)
          state_d = (rx_data == SIGEOF) ? S_DONE : S_ERR;
      end
      S_FILL: begin
        cur_adv = 1'b1;
        if (cur_last) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (timeout_hit) state_d = S_ERR;
  end

  // Registered outputs derived from the current step and next state.
  always_comb begin
    write_en_d   = cur_adv;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    if (cur_adv) begin
      write_addr_d = {cur_row, cur_col};
      write_data_d = (state_q == S_RECV) ? to_code(rx_data) : 8'h00;
    end
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    error_d = error_q;
    if (state_q == S_IDLE && start) error_d = 1'b0;
    else if (state_d == S_ERR)      error_d = 1'b1;
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_en_q   <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      write_en_q   <= write_en_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign write_en   = write_en_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_doc_loader.sv
// Scoreboard bench for doc_loader: expected writes queued at stimulus time,
// popped by a negedge monitor; randomized documents from a page model.
module tb_doc_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       rx_data_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       write_en;
  logic [8:0] write_addr;
  logic [7:0] write_data;
  logic       busy;
  logic       done;
  logic       error;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  logic [16:0] sb[$];

  always #5 clk = ~clk;

  doc_loader #(.TIMEOUT_CYCLES(24'd1000)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .rx_data_valid (rx_data_valid),
    .rx_data       (rx_data),
    .write_en      (write_en),
    .write_addr    (write_addr),
    .write_data    (write_data),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Page model: character index i lives at row i/20, col i%20.
  function automatic logic [8:0] addr_of(input int i);
    logic [3:0] r;
    logic [4:0] c;
    r = 4'(i / 20);
    c = 5'(i % 20);
    return {r, c};
  endfunction

  function automatic logic [7:0] code_of(input logic [7:0] b);
    int v;
    v = int'(b);
    if (v >= 32 && v <= 126) return 8'(v - 32);
    return 8'h00;
  endfunction

  // Monitor: every write must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset) begin
      if (done) done_cnt++;
      if (write_en) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h",
                   write_addr, write_data);
        end else begin
          logic [16:0] e;
          e = sb.pop_front();
          if ({write_addr, write_data} !== e) begin
            fails++;
            $display("FAIL write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                     write_addr, write_data, e[16:8], e[7:0]);
          end
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One received byte; write_en must follow exactly one cycle later iff expw.
  task automatic send(input logic [7:0] b, input bit expw);
    @(negedge clk);
    rx_data_valid = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_data_valid = 1'b0;
    rx_data = 8'h00;
    chk("write_latency", {31'd0, write_en}, {31'd0, expw});
    repeat (3) @(negedge clk);
  endtask

  // Sends CC, payload, then term; pushes the page model's expected writes.
  task automatic load_doc(input logic [7:0] pl[$], input logic [7:0] term,
                          input bit exp_ok);
    int d0;
    int k;
    d0 = done_cnt;
    for (int i = 0; i < pl.size(); i++)
      sb.push_back({addr_of(i), code_of(pl[i])});
    if (pl.size() < 300)
      for (int i = pl.size(); i < 300; i++)
        sb.push_back({addr_of(i), 8'h00});
    send(8'hCC, 1'b0);
    foreach (pl[i]) send(pl[i], 1'b1);
    send(term, 1'b0);
    k = 0;
    while (done_cnt == d0 && !error && k < 700) begin
      @(negedge clk);
      k++;
    end
    chk("finish_in_time", {31'd0, k < 700}, 32'd1);
    @(negedge clk);
    chk("done_pulses", done_cnt - d0, exp_ok ? 32'd1 : 32'd0);
    chk("error_flag", {31'd0, error}, {31'd0, !exp_ok});
    chk("busy_after", {31'd0, busy}, 32'd0);
    chk("sb_drained", sb.size(), 32'd0);
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    if (b == 8'hDD) b = 8'h0A;
    return b;
  endfunction

  initial begin
    logic [7:0] pl[$];
    int n;
    int k;

    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_wen", {31'd0, write_en}, 32'd0);
    chk("rst_addr", {23'd0, write_addr}, 32'd0);
    chk("rst_data", {24'd0, write_data}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Full page of 'A'.
    pl = {};
    for (int i = 0; i < 300; i++) pl.push_back(8'h41);
    pulse_start();
    chk("busy_armed", {31'd0, busy}, 32'd1);
    load_doc(pl, 8'hDD, 1'b1);

    // Junk before SIGACK is discarded; first char 'B'.
    pl = {8'h42};
    for (int i = 1; i < 300; i++) pl.push_back(rand_byte());
    pulse_start();
    send(8'h41, 1'b0);
    send(8'h55, 1'b0);
    load_doc(pl, 8'hDD, 1'b1);

    // Early EOF after "Hi": remaining cells filled with spaces.
    pl = {8'h48, 8'h69};
    pulse_start();
    load_doc(pl, 8'hDD, 1'b1);

    // Wrong terminator: error, no done; next start clears error.
    pl = {};
    for (int i = 0; i < 300; i++) pl.push_back(rand_byte());
    pulse_start();
    load_doc(pl, 8'h41, 1'b0);
    pulse_start();
    chk("error_cleared", {31'd0, error}, 32'd0);
    chk("start_ignored_busy", {31'd0, busy}, 32'd1);
    pl = {};
    for (int i = 0; i < 300; i++) pl.push_back(rand_byte());
    load_doc(pl, 8'hDD, 1'b1);

    // Newline written as space, then reset mid-load.
    pl = {8'h0A};
    for (int i = 1; i < 150; i++) pl.push_back(rand_byte());
    pulse_start();
    for (int i = 0; i < 150; i++) sb.push_back({addr_of(i), code_of(pl[i])});
    send(8'hCC, 1'b0);
    foreach (pl[i]) send(pl[i], 1'b1);
    chk("mid_sb_drained", sb.size(), 32'd0);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_outs", {write_en, done, error, write_addr, write_data},
        32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Randomized documents, some with early EOF.
    for (int t = 0; t < 4; t++) begin
      n = (t == 0) ? 0 : $urandom_range(1, 300);
      pl = {};
      for (int i = 0; i < n; i++) pl.push_back(rand_byte());
      pulse_start();
      load_doc(pl, 8'hDD, 1'b1);
    end

`ifdef DOC_LOADER_TIMEOUT_EN
    pulse_start();
    send(8'hCC, 1'b0);
    k = 0;
    while (!error && k < 1200) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk("timeout_error", {31'd0, error}, 32'd1);
    chk("timeout_busy", {31'd0, busy}, 32'd0);
`else
    pulse_start();
    send(8'hCC, 1'b0);
    repeat (1200) @(negedge clk);
    chk("no_timeout_error", {31'd0, error}, 32'd0);
    chk("no_timeout_busy", {31'd0, busy}, 32'd1);
    k = 0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
`endif
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
